// File: rtl/dbg_cmd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_cmd_bridge
//  Purpose  : Host-command bridge between a byte-stream UART pair and the
//             u8dbg serial debug engine. Parses framed burst read / burst
//             write / ping commands, runs register accesses with address
//             auto-increment, enforces a per-access timeout and returns
//             status and read data bytes.
//
//  Frame    : cmd, reg, count N, then (writes only) N words of DATA_BYTES
//             bytes each, MSB first.
//  Status   : 0x10 ok, 0xE0 bad command, 0xE1 bad count, 0xE2 timeout.
//
//  Ports    : clk, rst (async, active-high)
//             rx_tdata/rx_tvalid/rx_tready : inbound byte stream
//             tx_tdata/tx_tvalid/tx_tready : outbound byte stream
//             dbg_start/dbg_done           : debug access handshake
//             dbg_reg/dbg_dir/dbg_wdata    : access address, dir (1=read), data
//             dbg_rdata                    : read data, valid with dbg_done
//             busy                         : high whenever not idle
//
//  Revision : 1.0  initial release
// ============================================================================
module dbg_cmd_bridge #(
    parameter int DATA_BYTES = 2,      // debug word width in bytes
    parameter int REG_W      = 7,      // register address width, 1..8
    parameter int MAX_BURST  = 16,     // largest legal burst, 1..255
    parameter int TIMEOUT    = 65535   // max dbg_start-high cycles per access
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_tdata,
    input  logic                      rx_tvalid,
    output logic                      rx_tready,
    output logic [7:0]                tx_tdata,
    output logic                      tx_tvalid,
    input  logic                      tx_tready,
    output logic                      dbg_start,
    input  logic                      dbg_done,
    output logic [REG_W-1:0]          dbg_reg,
    output logic                      dbg_dir,
    output logic [8*DATA_BYTES-1:0]   dbg_wdata,
    input  logic [8*DATA_BYTES-1:0]   dbg_rdata,
    output logic                      busy
);

    localparam int DW  = 8 * DATA_BYTES;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;        // holds TIMEOUT-1
    localparam int BW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;  // holds DATA_BYTES-1
    localparam int DRW = $clog2(255 * DATA_BYTES + 1);               // holds 255*DATA_BYTES

    localparam logic [7:0]     c_cmd_read   = 8'h72;
    localparam logic [7:0]     c_cmd_write  = 8'h77;
    localparam logic [7:0]     c_cmd_ping   = 8'h70;
    localparam logic [7:0]     c_st_ok      = 8'h10;
    localparam logic [7:0]     c_st_bad_cmd = 8'hE0;
    localparam logic [7:0]     c_st_bad_cnt = 8'hE1;
    localparam logic [7:0]     c_st_timeout = 8'hE2;
    localparam logic [7:0]     c_max_burst  = 8'(MAX_BURST);
    localparam logic [TW-1:0]  c_timer_last = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0]  c_last_byte  = BW'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_REG   = 3'd1,
        S_GET_CNT   = 3'd2,
        S_GET_DATA  = 3'd3,
        S_RUN       = 3'd4,
        S_SEND_DATA = 3'd5,
        S_DRAIN     = 3'd6,
        S_SEND_STAT = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_dir;        // 1 = current frame is a burst read
    logic [REG_W-1:0] r_reg;        // address of the current / next access
    logic [7:0]       r_cnt;        // burst length N
    logic [7:0]       r_idx;        // index k of the current word
    logic [BW-1:0]    r_bcnt;       // byte position inside a word
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    r_rdata;      // shifts left as bytes are sent
    logic [TW-1:0]    r_timer;
    logic [DRW-1:0]   r_drain;      // bytes still to be discarded
    logic [7:0]       r_stat;       // status byte to send next
    logic             r_stat_data;  // status byte is followed by a data word

    logic             w_rx_fire;
    logic             w_tx_fire;
    logic             w_last_word;
    logic             w_last_byte;
    logic             w_timeout;
    logic             w_cnt_zero;
    logic             w_cnt_over;
    logic             w_is_rw;
    logic [7:0]       w_words_left;
    logic [DW-1:0]    w_wdata_shift;
    logic [DW-1:0]    w_rdata_shift;

    assign w_rx_fire    = rx_tvalid & rx_tready;
    assign w_tx_fire    = tx_tvalid & tx_tready;
    assign w_last_word  = (r_idx == r_cnt - 8'd1);
    assign w_last_byte  = (r_bcnt == c_last_byte);
    // dbg_done on the limit cycle wins over the timeout.
    assign w_timeout    = ~dbg_done & (r_timer == c_timer_last);
    assign w_cnt_zero   = (rx_tdata == 8'd0);
    assign w_cnt_over   = (rx_tdata > c_max_burst);
    assign w_is_rw      = (rx_tdata == c_cmd_read) | (rx_tdata == c_cmd_write);
    assign w_words_left = r_cnt - r_idx - 8'd1;

    // Byte-wide shift paths; a one-byte word has nothing to shift through.
    generate
        if (DATA_BYTES == 1) begin : g_single_byte
            assign w_wdata_shift = rx_tdata;
            assign w_rdata_shift = 8'h00;
        end else begin : g_multi_byte
            assign w_wdata_shift = {r_wdata[DW-9:0], rx_tdata};
            assign w_rdata_shift = {r_rdata[DW-9:0], 8'h00};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        rx_tready    = 1'b0;
        tx_tvalid    = 1'b0;
        tx_tdata     = 8'h00;
        dbg_start    = 1'b0;
        busy         = 1'b1;

        case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                rx_tready = 1'b1;
                if (w_rx_fire) begin
                    w_state_next = w_is_rw ? S_GET_REG : S_SEND_STAT;
                end
            end
            S_GET_REG: begin
                rx_tready = 1'b1;
                if (w_rx_fire) begin
                    w_state_next = S_GET_CNT;
                end
            end
            S_GET_CNT: begin
                rx_tready = 1'b1;
                if (w_rx_fire) begin
                    if (w_cnt_zero) begin
                        w_state_next = S_SEND_STAT;
                    end else if (w_cnt_over) begin
                        // Oversized writes still swallow their payload.
                        w_state_next = r_dir ? S_SEND_STAT : S_DRAIN;
                    end else begin
                        w_state_next = r_dir ? S_RUN : S_GET_DATA;
                    end
                end
            end
            S_GET_DATA: begin
                rx_tready = 1'b1;
                if (w_rx_fire && w_last_byte) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                dbg_start = 1'b1;
                if (dbg_done) begin
                    if (r_dir || w_last_word) begin
                        w_state_next = S_SEND_STAT;
                    end else begin
                        w_state_next = S_GET_DATA;
                    end
                end else if (w_timeout) begin
                    if (r_dir || w_last_word) begin
                        w_state_next = S_SEND_STAT;
                    end else begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_SEND_DATA: begin
                tx_tvalid = 1'b1;
                tx_tdata  = r_rdata[DW-1 -: 8];
                if (w_tx_fire && w_last_byte) begin
                    w_state_next = w_last_word ? S_IDLE : S_RUN;
                end
            end
            S_DRAIN: begin
                rx_tready = 1'b1;
                if (w_rx_fire && (r_drain == DRW'(1))) begin
                    w_state_next = S_SEND_STAT;
                end
            end
            S_SEND_STAT: begin
                tx_tvalid = 1'b1;
                tx_tdata  = r_stat;
                if (w_tx_fire) begin
                    w_state_next = r_stat_data ? S_SEND_DATA : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Async reset holds state at IDLE, where rx_tready would be 1.
        if (rst) begin
            rx_tready = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: frame fields, word buffers, counters, status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir       <= 1'b0;
            r_reg       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_bcnt      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_timer     <= '0;
            r_drain     <= '0;
            r_stat      <= '0;
            r_stat_data <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        r_dir       <= (rx_tdata == c_cmd_read);
                        r_stat_data <= 1'b0;
                        r_stat      <= (rx_tdata == c_cmd_ping) ? c_st_ok : c_st_bad_cmd;
                    end
                end
                S_GET_REG: begin
                    if (w_rx_fire) begin
                        r_reg <= rx_tdata[REG_W-1:0];
                    end
                end
                S_GET_CNT: begin
                    if (w_rx_fire) begin
                        r_cnt       <= rx_tdata;
                        r_idx       <= '0;
                        r_bcnt      <= '0;
                        // Bad-count status preloaded; a legal burst replaces it.
                        r_stat      <= c_st_bad_cnt;
                        r_stat_data <= 1'b0;
                        r_drain     <= DRW'(rx_tdata) * DRW'(DATA_BYTES);
                    end
                end
                S_GET_DATA: begin
                    if (w_rx_fire) begin
                        r_wdata <= w_wdata_shift;
                        r_bcnt  <= w_last_byte ? '0 : r_bcnt + BW'(1);
                    end
                end
                S_RUN: begin
                    if (dbg_done) begin
                        if (r_dir) begin
                            r_rdata     <= dbg_rdata;
                            r_stat      <= c_st_ok;
                            r_stat_data <= 1'b1;
                        end else if (w_last_word) begin
                            r_stat <= c_st_ok;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                            r_reg <= r_reg + REG_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_stat      <= c_st_timeout;
                        r_stat_data <= 1'b0;
                        // Remaining write payload is discarded before 0xE2.
                        r_drain     <= DRW'(w_words_left) * DRW'(DATA_BYTES);
                    end
                end
                S_SEND_DATA: begin
                    if (w_tx_fire) begin
                        r_rdata <= w_rdata_shift;
                        r_bcnt  <= w_last_byte ? '0 : r_bcnt + BW'(1);
                        if (w_last_byte && !w_last_word) begin
                            r_idx <= r_idx + 8'd1;
                            r_reg <= r_reg + REG_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_rx_fire) begin
                        r_drain <= r_drain - DRW'(1);
                    end
                end
                default: begin
                end
            endcase

            // Counts dbg_start-high cycles of the current access only.
            if (r_state == S_RUN && !dbg_done && !w_timeout) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign dbg_reg   = r_reg;
    assign dbg_dir   = r_dir;
    assign dbg_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dbg_cmd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbg_cmd_bridge
//  Purpose  : Self-checking bench for dbg_cmd_bridge. Frames are compared
//             against a frame-level reference model (expected tx bytes and
//             expected debug accesses); a debug-engine responder answers
//             accesses from a per-frame plan of latencies and read data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dbg_cmd_bridge;

    localparam int DB   = 2;
    localparam int RW   = 7;
    localparam int MAXB = 16;
    localparam int TO   = 8;
    localparam int DW   = 8 * DB;

    typedef struct {
        logic [RW-1:0] rg;
        logic          dir;
        logic [DW-1:0] wd;
        int            dur;
    } acc_t;

    typedef struct {
        int            lat;
        logic [DW-1:0] rdata;
        bit            never;
    } plan_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_tdata;
    logic          rx_tvalid;
    logic          rx_tready;
    logic [7:0]    tx_tdata;
    logic          tx_tvalid;
    logic          tx_tready;
    logic          dbg_start;
    logic          dbg_done;
    logic [RW-1:0] dbg_reg;
    logic          dbg_dir;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          busy;

    dbg_cmd_bridge #(
        .DATA_BYTES (DB),
        .REG_W      (RW),
        .MAX_BURST  (MAXB),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .dbg_start (dbg_start),
        .dbg_done  (dbg_done),
        .dbg_reg   (dbg_reg),
        .dbg_dir   (dbg_dir),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [7:0] frame_q[$];
    plan_t      plan_m[$];
    plan_t      plan_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] tx_obs[$];
    acc_t       exp_acc[$];
    acc_t       acc_obs[$];

    int   stable_err  = 0;
    int   hold_err    = 0;
    int   last_tx_cyc = 0;
    int   bp_hold     = 0;
    bit   bp_arm      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: expected tx bytes and accesses for frame_q/plan_m
    // ------------------------------------------------------------------
    function automatic void build_expected();
        logic [7:0] cmd;
        int         n;
        int         base;
        bit         stop;
        acc_t       a;
        plan_t      p;
        exp_tx.delete();
        exp_acc.delete();
        cmd = frame_q[0];
        if (cmd == 8'h70) begin
            exp_tx.push_back(8'h10);
        end else if (cmd != 8'h72 && cmd != 8'h77) begin
            exp_tx.push_back(8'hE0);
        end else begin
            base = int'(frame_q[1]);
            n    = int'(frame_q[2]);
            if (n == 0 || n > MAXB) begin
                exp_tx.push_back(8'hE1);
            end else begin
                stop = 0;
                for (int k = 0; k < n && !stop; k++) begin
                    p     = plan_m[k];
                    a.rg  = RW'((base + k) % (1 << RW));
                    a.dir = (cmd == 8'h72);
                    a.wd  = a.dir ? '0 : {frame_q[3 + 2*k], frame_q[4 + 2*k]};
                    a.dur = p.never ? TO : p.lat;
                    exp_acc.push_back(a);
                    if (p.never) begin
                        exp_tx.push_back(8'hE2);
                        stop = 1;
                    end else if (a.dir) begin
                        exp_tx.push_back(8'h10);
                        exp_tx.push_back(p.rdata[15:8]);
                        exp_tx.push_back(p.rdata[7:0]);
                    end
                end
                if (cmd == 8'h77 && !stop) begin
                    exp_tx.push_back(8'h10);
                end
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Cycle counter, tx_tready driver, tx monitor, debug responder
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        tx_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold > 0) begin
                tx_tready = 1'b0;
                bp_hold--;
            end else begin
                tx_tready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        bit         pend;
        logic [7:0] pdata;
        pend  = 0;
        pdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
            end else begin
                if (pend && (!tx_tvalid || tx_tdata !== pdata)) hold_err++;
                if (tx_tvalid && tx_tready) begin
                    tx_obs.push_back(tx_tdata);
                    last_tx_cyc = cyc;
                    if (bp_arm) begin
                        bp_hold = 20;
                        bp_arm  = 0;
                    end
                end
                pend  = tx_tvalid && !tx_tready;
                pdata = tx_tdata;
            end
        end
    end

    initial begin
        acc_t  cur;
        plan_t cp;
        bit    active;
        active    = 0;
        dbg_done  = 1'b0;
        dbg_rdata = '0;
        cur       = '{rg: '0, dir: 1'b0, wd: '0, dur: 0};
        cp        = '{lat: 1, rdata: '0, never: 1'b0};
        forever begin
            @(negedge clk);
            if (dbg_start) begin
                if (!active) begin
                    active  = 1;
                    cur.rg  = dbg_reg;
                    cur.dir = dbg_dir;
                    cur.wd  = dbg_wdata;
                    cur.dur = 0;
                    if (plan_q.size() > 0) cp = plan_q.pop_front();
                    else cp = '{lat: 1, rdata: '0, never: 1'b0};
                end else if (dbg_reg !== cur.rg || dbg_dir !== cur.dir || dbg_wdata !== cur.wd) begin
                    stable_err++;
                end
                cur.dur++;
                if (!cp.never && cur.dur == cp.lat) begin
                    dbg_done  = 1'b1;
                    dbg_rdata = cp.rdata;
                end else begin
                    dbg_done  = 1'b0;
                    dbg_rdata = DW'($urandom);
                end
            end else begin
                if (active) begin
                    acc_obs.push_back(cur);
                    active = 0;
                end
                dbg_done = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, output bit ok);
        bit rdy;
        int gap;
        ok  = 0;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            rdy = rx_tready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1;
        end
        rx_tvalid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add_plan(input int lat, input logic [DW-1:0] rd, input bit never);
        plan_t p;
        p.lat   = lat;
        p.rdata = rd;
        p.never = never;
        plan_m.push_back(p);
    endtask

    task automatic run_txn();
        bit ok;
        bit bok;
        int t;
        int n_acc;
        tx_obs.delete();
        acc_obs.delete();
        stable_err = 0;
        hold_err   = 0;
        plan_q     = plan_m;
        build_expected();

        ok = 1;
        foreach (frame_q[i]) begin
            if (ok) begin
                send_byte(frame_q[i], bok);
                if (!bok) ok = 0;
            end
        end
        chk("rx_accept", 32'(ok), 32'd1);
        if (ok) begin
            chk("busy_rise", 32'(busy), 32'd1);
            if (frame_q.size() == 1) chk("stat_latency", 32'(tx_tvalid), 32'd1);
            if (frame_q[0] == 8'h72 && frame_q[2] != 8'h00 && int'(frame_q[2]) <= MAXB)
                chk("start_latency", 32'(dbg_start), 32'd1);
        end

        t = 0;
        while (busy && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
        if (busy) begin
            pulse_reset();
        end else begin
            chk("busy_fall", 32'(cyc), 32'(last_tx_cyc + 1));
        end
        repeat (2) @(posedge clk);
        #1;

        chk("tx_len", 32'(tx_obs.size()), 32'(exp_tx.size()));
        foreach (exp_tx[i]) begin
            if (i < tx_obs.size()) chk("tx_byte", 32'(tx_obs[i]), 32'(exp_tx[i]));
        end
        chk("acc_count", 32'(acc_obs.size()), 32'(exp_acc.size()));
        n_acc = (acc_obs.size() < exp_acc.size()) ? acc_obs.size() : exp_acc.size();
        for (int i = 0; i < n_acc; i++) begin
            chk("acc_reg", 32'(acc_obs[i].rg), 32'(exp_acc[i].rg));
            chk("acc_dir", 32'(acc_obs[i].dir), 32'(exp_acc[i].dir));
            if (!exp_acc[i].dir) chk("acc_wdata", 32'(acc_obs[i].wd), 32'(exp_acc[i].wd));
            chk("acc_start_len", 32'(acc_obs[i].dur), 32'(exp_acc[i].dur));
        end
        chk("acc_stable", 32'(stable_err), 32'd0);
        chk("tx_hold", 32'(hold_err), 32'd0);
    endtask

    task automatic gen_random();
        int         kind;
        int         sel;
        int         n;
        logic [7:0] b;
        frame_q.delete();
        plan_m.delete();
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            frame_q.push_back(8'h70);
        end else if (kind == 1) begin
            do b = 8'($urandom); while (b == 8'h70 || b == 8'h72 || b == 8'h77);
            frame_q.push_back(b);
        end else begin
            frame_q.push_back((kind < 6) ? 8'h72 : 8'h77);
            sel = $urandom_range(0, 3);
            frame_q.push_back((sel == 0) ? 8'($urandom_range(8'h7D, 8'h7F)) : 8'($urandom));
            sel = $urandom_range(0, 9);
            if (sel == 0)      n = 0;
            else if (sel == 1) n = $urandom_range(MAXB + 1, MAXB + 4);
            else if (sel == 2) n = MAXB;
            else               n = $urandom_range(1, 4);
            frame_q.push_back(8'(n));
            if (kind >= 6 && n > 0) begin
                for (int i = 0; i < n * DB; i++) frame_q.push_back(8'($urandom));
            end
            if (n > 0 && n <= MAXB) begin
                for (int i = 0; i < n; i++)
                    add_plan($urandom_range(1, TO), DW'($urandom), ($urandom_range(0, 11) == 0));
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_tready", 32'(rx_tready), 32'd0);
        chk("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
        chk("rst_dbg_start", 32'(dbg_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dbg_reg", 32'(dbg_reg), 32'd0);
        chk("rst_dbg_wdata", 32'(dbg_wdata), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_rx_tready", 32'(rx_tready), 32'd1);

        // Ping
        frame_q = '{8'h70}; plan_m.delete();
        run_txn();

        // Read burst 72 05 02, done after 3 cycles, BEEF then 1234
        frame_q = '{8'h72, 8'h05, 8'h02}; plan_m.delete();
        add_plan(3, 16'hBEEF, 1'b0);
        add_plan(3, 16'h1234, 1'b0);
        run_txn();

        // Write burst with address wrap 7F -> 00
        frame_q = '{8'h77, 8'h7F, 8'h02, 8'hAA, 8'h55, 8'h01, 8'h02}; plan_m.delete();
        add_plan(2, 16'h0000, 1'b0);
        add_plan(4, 16'h0000, 1'b0);
        run_txn();

        // Write timeout on first word, second word drained
        frame_q = '{8'h77, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44}; plan_m.delete();
        add_plan(1, 16'h0000, 1'b1);
        add_plan(1, 16'h0000, 1'b1);
        run_txn();

        // Read timeout, and done exactly on the limit cycle
        frame_q = '{8'h72, 8'h20, 8'h02}; plan_m.delete();
        add_plan(TO, 16'hCAFE, 1'b0);
        add_plan(1, 16'h0000, 1'b1);
        run_txn();

        // Errors
        frame_q = '{8'h41}; plan_m.delete();
        run_txn();
        frame_q = '{8'h72, 8'h00, 8'h00}; plan_m.delete();
        run_txn();
        frame_q = '{8'h72, 8'h00, 8'h11}; plan_m.delete();
        run_txn();
        frame_q = '{8'h77, 8'h00, 8'h14}; plan_m.delete();
        for (int i = 0; i < 40; i++) frame_q.push_back(8'($urandom));
        run_txn();
        frame_q = '{8'h70}; plan_m.delete();
        run_txn();

        // Backpressure: tx_tready low 20 cycles after the first response byte
        frame_q = '{8'h72, 8'h30, 8'h03}; plan_m.delete();
        add_plan(2, 16'hA5C3, 1'b0);
        add_plan(1, 16'h0FF0, 1'b0);
        add_plan(5, 16'h7E81, 1'b0);
        bp_arm = 1;
        run_txn();

        // Reset in the middle of an access
        begin
            bit bok;
            frame_q = '{8'h72, 8'h10, 8'h01}; plan_m.delete();
            plan_q.delete();
            add_plan(1, 16'h0000, 1'b1);
            plan_q = plan_m;
            foreach (frame_q[i]) send_byte(frame_q[i], bok);
            repeat (3) @(posedge clk);
            #1;
            chk("pre_rst_dbg_start", 32'(dbg_start), 32'd1);
            rst = 1'b1;
            #1;
            chk("mid_rst_dbg_start", 32'(dbg_start), 32'd0);
            chk("mid_rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
            chk("mid_rst_rx_tready", 32'(rx_tready), 32'd0);
            chk("mid_rst_busy", 32'(busy), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        frame_q = '{8'h70}; plan_m.delete();
        run_txn();

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            gen_random();
            run_txn();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
